// File: rtl/pwm_duty_slew.sv
// pwm_duty_slew: slew-rate limiter between the duty register and the PWM duty input.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   target_duty   requested duty from the SPI duty register
//   ramp_en       1 = slew-limited, 0 = jump to target at next period boundary
//   step          duty increment per update (0 freezes duty_out)
//   rate          one update every rate+1 period boundaries
//   period_start  one-cycle pulse at PWM counter wrap
//   duty_out      applied duty to the PWM peripheral
//   busy          high while duty_out differs from target
//   at_target     one-cycle pulse when a ramp completes
module pwm_duty_slew #(
  parameter int DUTY_W = 8,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              ramp_en,
  input  logic [3:0]        step,
  input  logic [RATE_W-1:0] rate,
  input  logic              period_start,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              at_target
);
  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;
  state_t            state;
  logic [DUTY_W-1:0] target_q;
  logic [RATE_W-1:0] cnt;
  logic [DUTY_W:0]   up_diff;
  logic [DUTY_W:0]   dn_diff;
  logic [DUTY_W:0]   step_x;
  logic [DUTY_W-1:0] duty_nxt;
  logic              upd;
  // Moves are only taken when the registered direction still agrees with the
  // live comparison, so a target change racing a period boundary never jumps.
  always_comb begin
    up_diff  = {1'b0, target_q} - {1'b0, duty_out};
    dn_diff  = {1'b0, duty_out} - {1'b0, target_q};
    step_x   = (DUTY_W+1)'(step);
    upd      = period_start && state != IDLE && (!ramp_en || cnt == rate);
    duty_nxt = !ramp_en ? target_q :
               (state == RAMP_UP && target_q > duty_out) ?
                 (up_diff <= step_x ? target_q : duty_out + DUTY_W'(step)) :
               (state == RAMP_DOWN && target_q < duty_out) ?
                 (dn_diff <= step_x ? target_q : duty_out - DUTY_W'(step)) :
               duty_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q  <= '0;
      state     <= IDLE;
      cnt       <= '0;
      duty_out  <= '0;
      busy      <= 1'b0;
      at_target <= 1'b0;
    end else begin
      target_q  <= target_duty;
      state     <= duty_out == target_q ? IDLE : target_q > duty_out ? RAMP_UP : RAMP_DOWN;
      busy      <= duty_out != target_q;
      at_target <= state != IDLE && duty_out == target_q;
      cnt       <= (state == IDLE || !ramp_en) ? '0 :
                   period_start ? (cnt == rate ? '0 : cnt + 1'b1) : cnt;
      if (upd) duty_out <= duty_nxt;
    end
  end
endmodule

// File: tb/tb_pwm_duty_slew.sv
// tb_pwm_duty_slew: directed bench with a cycle model of the duty slew limiter.
module tb_pwm_duty_slew;
  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] target_duty = 0;
  logic       ramp_en = 1;
  logic [3:0] step = 0;
  logic [7:0] rate = 0;
  logic       period_start = 0;
  logic [7:0] duty_out;
  logic       busy;
  logic       at_target;
  int total = 0;
  int bad = 0;
  int m_tq = 0, m_duty = 0, m_dir = 0, m_cnt = 0, m_at = 0;
  int at_cnt = 0;
  int last = 0;
  bit chk_on = 0;
  int chg[$];
  pwm_duty_slew dut (
    .clk(clk), .rst(rst), .target_duty(target_duty), .ramp_en(ramp_en),
    .step(step), .rate(rate), .period_start(period_start),
    .duty_out(duty_out), .busy(busy), .at_target(at_target)
  );
  always #5 clk = ~clk;
  function automatic void check(string n, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction
  // Model: direction is the sign of (target - duty) seen one cycle earlier; an
  // update moves duty by at most step toward the target.
  always @(posedge clk) begin
    int nd, d, t;
    if (rst) begin
      m_tq = 0; m_duty = 0; m_dir = 0; m_cnt = 0; m_at = 0;
    end else begin
      d = m_duty; t = m_tq; nd = d;
      if (period_start && m_dir != 0) begin
        if (!ramp_en) nd = t;
        else if (m_cnt == int'(rate)) begin
          if (m_dir > 0 && t > d) nd = d + ((t - d) < int'(step) ? t - d : int'(step));
          if (m_dir < 0 && t < d) nd = d - ((d - t) < int'(step) ? d - t : int'(step));
        end
      end
      if (m_dir == 0 || !ramp_en) m_cnt = 0;
      else if (period_start) m_cnt = (m_cnt == int'(rate)) ? 0 : m_cnt + 1;
      m_at = (m_dir != 0 && d == t) ? 1 : 0;
      m_dir = (t > d) ? 1 : (t < d) ? -1 : 0;
      m_tq = int'(target_duty);
      m_duty = nd;
    end
  end
  always @(negedge clk) if (chk_on) begin
    check("duty_model", int'(duty_out), m_duty);
    check("busy_model", int'(busy), int'(m_dir != 0));
    check("at_model", int'(at_target), m_at);
    if (int'(duty_out) != last) chg.push_back(int'(duty_out));
    last = int'(duty_out);
    if (at_target) at_cnt++;
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulses(int n, int gap);
    repeat (n) begin
      period_start = 1;
      @(negedge clk);
      period_start = 0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask
  task automatic load(int v);
    ramp_en = 0;
    target_duty = 8'(v);
    cyc(3);
    pulses(1, 4);
    ramp_en = 1;
  endtask
  initial begin
    target_duty = 8'hFF;
    @(negedge clk);
    period_start = 1;
    @(posedge clk);
    chk_on = 1;
    @(negedge clk);
    period_start = 0;
    check("rst_duty", int'(duty_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_at", int'(at_target), 0);
    rst = 0;
    cyc(4);
    check("post_rst_duty", int'(duty_out), 0);
    check("post_rst_busy", int'(busy), 1);
    target_duty = 0;
    cyc(4);
    step = 10; rate = 0; ramp_en = 1;
    target_duty = 100;
    cyc(3);
    chg.delete(); at_cnt = 0;
    pulses(10, 4);
    check("up_count", chg.size(), 10);
    for (int i = 0; i < 10 && i < chg.size(); i++) check("up_seq", chg[i], 10 * (i + 1));
    check("up_at", at_cnt, 1);
    check("up_busy", int'(busy), 0);
    load(95);
    check("load95", int'(duty_out), 95);
    step = 8;
    target_duty = 3;
    cyc(3);
    chg.delete();
    pulses(12, 4);
    check("dn_count", chg.size(), 12);
    if (chg.size() == 12) begin
      check("dn_first", chg[0], 87);
      check("dn_pen", chg[10], 7);
      check("dn_last", chg[11], 3);
    end
    target_duty = 0;
    cyc(3);
    chg.delete();
    pulses(1, 4);
    check("dn_zero_count", chg.size(), 1);
    check("dn_zero", int'(duty_out), 0);
    rate = 2; step = 1;
    target_duty = 3;
    cyc(3);
    chg.delete();
    pulses(2, 4);
    check("rate_hold", int'(duty_out), 0);
    pulses(1, 4);
    check("rate_first", int'(duty_out), 1);
    pulses(6, 4);
    check("rate_final", int'(duty_out), 3);
    check("rate_count", chg.size(), 3);
    load(0);
    ramp_en = 0;
    target_duty = 200;
    cyc(3);
    chg.delete(); at_cnt = 0;
    pulses(1, 4);
    check("byp_count", chg.size(), 1);
    check("byp_duty", int'(duty_out), 200);
    check("byp_at", at_cnt, 1);
    rate = 0; step = 10;
    load(30);
    target_duty = 100;
    cyc(3);
    pulses(2, 4);
    check("rev_start", int'(duty_out), 50);
    target_duty = 20;
    cyc(3);
    chg.delete();
    pulses(3, 4);
    check("rev_count", chg.size(), 3);
    if (chg.size() == 3) begin
      check("rev_0", chg[0], 40);
      check("rev_1", chg[1], 30);
      check("rev_2", chg[2], 20);
    end
    target_duty = 150;
    cyc(3);
    pulses(1, 2);
    check("mid_duty", int'(duty_out), 30);
    check("mid_busy", int'(busy), 1);
    at_cnt = 0;
    rst = 1;
    target_duty = 0;
    @(negedge clk);
    check("mrst_duty", int'(duty_out), 0);
    check("mrst_busy", int'(busy), 0);
    rst = 0;
    cyc(4);
    check("mrst_at", at_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
